alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//   Operand/command issue stage that sits directly upstream of the 32-bit ALU.
//   Buffers {operandA, operandB, command} requests in a DEPTH-entry FIFO.
//   Drives the FIFO head onto the ALU inputs and registers the ALU result and flags into a response slot.
//   The response slot uses a valid/ready handshake toward the downstream consumer.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must match the ALU
//   DEPTH  4   FIFO entries; power of two, >= 2
//   CMD_W  3   command width (ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7)
// PORTS
//   clk          in   1              single clock, rising edge
//   rst_n        in   1              asynchronous active-low reset
//   req_valid    in   1              request present
//   req_ready    out  1              queue can accept a request this cycle
//   req_a        in   WIDTH          operand A
//   req_b        in   WIDTH          operand B
//   req_cmd      in   CMD_W          ALU command
//   alu_a        out  WIDTH          to ALU operandA (FIFO head)
//   alu_b        out  WIDTH          to ALU operandB (FIFO head)
//   alu_cmd      out  CMD_W          to ALU command (FIFO head)
//   alu_result   in   WIDTH          from ALU result
//   alu_cout     in   1              from ALU carryout
//   alu_zero     in   1              from ALU zero
//   alu_ovf      in   1              from ALU overflow
//   rsp_valid    out  1              response slot holds a result
//   rsp_ready    in   1              consumer takes the response
//   rsp_result   out  WIDTH          registered result
//   rsp_cout     out  1              registered carryout
//   rsp_zero     out  1              registered zero
//   rsp_ovf      out  1              registered overflow
//   rsp_cmd      out  CMD_W          command that produced the response
//   count        out  $clog2(DEPTH)+1  FIFO occupancy, excluding the response slot
//   sticky_ovf   out  1              present only with STICKY_OVF_EN
//   sticky_clr   in   1              present only with STICKY_OVF_EN
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous): count=0, read/write pointers=0, rsp_valid=0, all rsp_*=0, sticky_ovf=0.
//     Reset mid-operation discards all queued entries and any held response immediately.
//   - req_ready = (count < DEPTH). Ready is registered-state only; there is no full-queue pass-through.
//     Push on req_valid && req_ready: write entry at wr_ptr, then wr_ptr = wr_ptr + 1 mod DEPTH.
//   - When count > 0, alu_a/alu_b/alu_cmd present the head entry combinationally. When count == 0 they are driven to 0.
//   - Pop condition: count > 0 && (!rsp_valid || rsp_ready).
//     On pop: capture alu_result/cout/zero/ovf and head cmd into rsp_*; set rsp_valid=1; rd_ptr = rd_ptr + 1 mod DEPTH.
//   - If rsp_valid && rsp_ready and no pop occurs, rsp_valid=0 (rsp_* data held).
//   - rsp_* must remain stable while rsp_valid && !rsp_ready.
//   - Simultaneous push and pop: count unchanged, both pointers advance.
//   - Latency: with the queue empty, a request accepted at edge k gives rsp_valid=1 after edge k+1.
//     Sustained throughput is 1 op/cycle with rsp_ready=1.
//   - Total capacity is DEPTH+1 operations (FIFO plus response slot). Ordering is strictly FIFO.
//   - The block does not interpret commands; cmd and all flags pass through unmodified.
// CONFIGURATION
//   STICKY_OVF_EN defined:
//     sticky_ovf is set on any pop where alu_ovf=1 and cmd is ADD or SUB.
//     It is cleared by sticky_clr=1 at the clock edge. If set and clear occur in the same cycle, set wins.
//   STICKY_OVF_EN undefined: sticky_ovf and sticky_clr ports and their logic are absent.
// TESTING
//   1. Reset, rsp_ready=1, push a=2 b=1 cmd=ADD -> next cycle rsp_valid=1, rsp_result=3, rsp_zero=0, rsp_ovf=0, rsp_cmd=0.
//   2. rsp_ready=0, DEPTH=4, push 6 requests a=1..6 b=0 cmd=OR
//      -> 5 accepted, req_ready=0 with count=4, rsp_result=1 held.
//      Then raise rsp_ready -> results 1,2,3,4,5 on consecutive cycles.
//   3. Push a=32'h7FFFFFFF b=1 cmd=ADD -> rsp_result=32'h80000000, rsp_ovf=1.
//      With STICKY_OVF_EN, sticky_ovf=1 until sticky_clr pulses.
//   4. Push a=5 b=5 cmd=SUB -> rsp_result=0, rsp_zero=1. Then a=-7 b=5 cmd=SLT -> rsp_result=1.
//   5. Steady stream with count=2 and rsp_ready=1, push every cycle -> count stays 2, one response per cycle, in order.
//   6. count=3 with rsp_valid=1, assert rst_n=0 between edges -> count=0, rsp_valid=0, req_ready=1 without a clock edge.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Issue stage in front of the 32-bit ALU. Requests {a, b, cmd} are buffered
//   in a DEPTH-entry FIFO. The FIFO head drives the ALU inputs combinationally.
//   The ALU result and flags are captured into a response slot, which is
//   drained with a valid/ready handshake.
//
// Optional feature: define STICKY_OVF_EN to add sticky_ovf/sticky_clr. The
//   sticky bit is set on an ADD/SUB pop with overflow. If a set and a clear
//   happen in the same cycle, the set wins.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/ready       request handshake; req_a, req_b, req_cmd payload
//   alu_a/alu_b/alu_cmd   FIFO head toward ALU (zero when empty)
//   alu_result/cout/zero/ovf  combinational ALU outputs
//   rsp_valid/ready       response handshake; rsp_* registered payload
//   count                 FIFO occupancy (response slot excluded)
//   sticky_ovf, sticky_clr    only with STICKY_OVF_EN
module alu_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CMD_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  input  logic [CMD_W-1:0]         req_cmd,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [CMD_W-1:0]         alu_cmd,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_cout,
  input  logic                     alu_zero,
  input  logic                     alu_ovf,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_cout,
  output logic                     rsp_zero,
  output logic                     rsp_ovf,
  output logic [CMD_W-1:0]         rsp_cmd,
  output logic [$clog2(DEPTH):0]   count
`ifdef STICKY_OVF_EN
  ,
  output logic                     sticky_ovf,
  input  logic                     sticky_clr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [CMD_W-1:0] mem_cmd [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          non_empty;
  logic          push;
  logic          pop;

  assign non_empty = (count != '0);
  assign req_ready = (count < FULL_CNT);
  assign push      = req_valid && req_ready;
  assign pop       = non_empty && (!rsp_valid || rsp_ready);

  assign alu_a   = non_empty ? mem_a[rd_ptr]   : '0;
  assign alu_b   = non_empty ? mem_b[rd_ptr]   : '0;
  assign alu_cmd = non_empty ? mem_cmd[rd_ptr] : '0;

  // Storage needs no reset: entries are only observable while count > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= req_a;
      mem_b[wr_ptr]   <= req_b;
      mem_cmd[wr_ptr] <= req_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The response slot is reloaded whenever it is empty or is being consumed.
  // Its data is held otherwise, including after it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_cmd    <= '0;
    end else if (pop) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_cout   <= alu_cout;
      rsp_zero   <= alu_zero;
      rsp_ovf    <= alu_ovf;
      rsp_cmd    <= alu_cmd;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef STICKY_OVF_EN
  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(1);

  logic ovf_set;
  assign ovf_set = pop && alu_ovf && ((alu_cmd == CMD_ADD) || (alu_cmd == CMD_SUB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sticky_ovf <= 1'b0;
    else if (ovf_set)    sticky_ovf <= 1'b1;
    else if (sticky_clr) sticky_ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CMD_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  req_a, req_b;
  logic [CMD_W-1:0]  req_cmd;
  logic [WIDTH-1:0]  alu_a, alu_b;
  logic [CMD_W-1:0]  alu_cmd;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_cout, alu_zero, alu_ovf;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_cout, rsp_zero, rsp_ovf;
  logic [CMD_W-1:0]  rsp_cmd;
  logic [2:0]        count;
`ifdef STICKY_OVF_EN
  logic              sticky_ovf;
  logic              sticky_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_cmd(rsp_cmd),
    .count(count)
`ifdef STICKY_OVF_EN
    , .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
`endif
  );

  // ALU reference behaviour, used both as the DUT's ALU and inside the model
  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        zero;
    logic        ovf;
  } alu_out_t;

  function automatic alu_out_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] cmd);
    alu_out_t o;
    logic [32:0] s;
    o = '0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        o.res = s[31:0]; o.cout = s[32];
        o.ovf = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.res = s[31:0]; o.cout = s[32];
        o.ovf = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'd2: o.res = a ^ b;
      3'd3: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: o.res = a & b;
      3'd5: o.res = ~(a & b);
      3'd6: o.res = ~(a | b);
      default: o.res = a | b;
    endcase
    o.zero = (o.res == 32'd0);
    return o;
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_fn(alu_a, alu_b, alu_cmd);
  assign alu_result = alu_o.res;
  assign alu_cout   = alu_o.cout;
  assign alu_zero   = alu_o.zero;
  assign alu_ovf    = alu_o.ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request queue plus one response slot
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  cmd;
  } req_t;

  req_t     mq[$];
  req_t     mh;
  alu_out_t mr;
  logic     m_valid;
  alu_out_t m_rsp;
  logic [2:0] m_cmd;
  logic     m_sticky;
  logic     m_push, m_pop, m_set;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid  = 1'b0;
      m_rsp    = '0;
      m_cmd    = '0;
      m_sticky = 1'b0;
    end else begin
      m_push = req_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() > 0) && (!m_valid || rsp_ready);
      m_set  = 1'b0;
      if (m_pop) begin
        mh      = mq.pop_front();
        mr      = alu_fn(mh.a, mh.b, mh.cmd);
        m_rsp   = mr;
        m_cmd   = mh.cmd;
        m_valid = 1'b1;
        m_set   = mr.ovf && (mh.cmd <= 3'd1);
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
`ifdef STICKY_OVF_EN
      if (m_set) m_sticky = 1'b1;
      else if (sticky_clr) m_sticky = 1'b0;
`endif
      if (m_push) mq.push_back('{a: req_a, b: req_b, cmd: req_cmd});
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("count", 64'(count), 64'(mq.size()));
    check("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
    check("alu_a", 64'(alu_a), 64'(mq.size() > 0 ? mq[0].a : 32'd0));
    check("alu_b", 64'(alu_b), 64'(mq.size() > 0 ? mq[0].b : 32'd0));
    check("alu_cmd", 64'(alu_cmd), 64'(mq.size() > 0 ? mq[0].cmd : 3'd0));
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_result", 64'(rsp_result), 64'(m_rsp.res));
    check("rsp_cout", 64'(rsp_cout), 64'(m_rsp.cout));
    check("rsp_zero", 64'(rsp_zero), 64'(m_rsp.zero));
    check("rsp_ovf", 64'(rsp_ovf), 64'(m_rsp.ovf));
    check("rsp_cmd", 64'(rsp_cmd), 64'(m_cmd));
`ifdef STICKY_OVF_EN
    check("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
`endif
  end

  // Drive n consecutive requests (one per cycle), a = a0 + i
  task automatic burst(input int n, input logic [31:0] a0, input logic [31:0] b,
                       input logic [2:0] cmd);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b1;
      req_a     = a0 + 32'(i);
      req_b     = b;
      req_cmd   = cmd;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_cmd = '0; rsp_ready = 1'b0;
`ifdef STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    idle(2);
    check("reset_count", 64'(count), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: single ADD, one-cycle latency
    rsp_ready = 1'b1;
    burst(1, 32'd2, 32'd1, 3'd0);
    idle(1);
    check("t1_valid", 64'(rsp_valid), 64'd1);
    check("t1_result", 64'(rsp_result), 64'd3);
    check("t1_zero", 64'(rsp_zero), 64'd0);
    check("t1_ovf", 64'(rsp_ovf), 64'd0);
    check("t1_cmd", 64'(rsp_cmd), 64'd0);
    idle(2);

    // 2: backpressure, capacity DEPTH+1, ordered drain
    rsp_ready = 1'b0;
    burst(6, 32'd1, 32'd0, 3'd7);
    check("t2_count", 64'(count), 64'd4);
    check("t2_ready", 64'(req_ready), 64'd0);
    check("t2_hold", 64'(rsp_result), 64'd1);
    idle(2);
    check("t2_hold_late", 64'(rsp_result), 64'd1);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("t2_drain_valid", 64'(rsp_valid), 64'd1);
      check("t2_drain", 64'(rsp_result), 64'(i));
      @(negedge clk);
    end
    check("t2_empty", 64'(rsp_valid), 64'd0);

    // 3: signed overflow on ADD
    burst(1, 32'h7FFF_FFFF, 32'd1, 3'd0);
    idle(1);
    check("t3_result", 64'(rsp_result), 64'h8000_0000);
    check("t3_ovf", 64'(rsp_ovf), 64'd1);
`ifdef STICKY_OVF_EN
    idle(2);
    check("t3_sticky", 64'(sticky_ovf), 64'd1);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("t3_sticky_clr", 64'(sticky_ovf), 64'd0);
`endif
    idle(2);

    // 4: SUB to zero, then SLT with a negative operand
    burst(1, 32'd5, 32'd5, 3'd1);
    idle(1);
    check("t4_sub_result", 64'(rsp_result), 64'd0);
    check("t4_sub_zero", 64'(rsp_zero), 64'd1);
    burst(1, 32'hFFFF_FFF9, 32'd5, 3'd3);
    idle(1);
    check("t4_slt", 64'(rsp_result), 64'd1);
    idle(2);

    // 5: steady stream at count=2
    rsp_ready = 1'b0;
    burst(3, 32'd100, 32'd3, 3'd2);
    check("t5_prefill", 64'(count), 64'd2);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_a = 32'd200 + 32'(i); req_b = 32'(i); req_cmd = 3'(i);
      @(negedge clk);
      check("t5_count", 64'(count), 64'd2);
      check("t5_valid", 64'(rsp_valid), 64'd1);
    end
    req_valid = 1'b0;
    idle(4);

    // 6: asynchronous reset with work in flight
    rsp_ready = 1'b0;
    burst(4, 32'd50, 32'd1, 3'd0);
    check("t6_pre_count", 64'(count), 64'd3);
    check("t6_pre_valid", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_count", 64'(count), 64'd0);
    check("t6_valid", 64'(rsp_valid), 64'd0);
    check("t6_ready", 64'(req_ready), 64'd1);
    check("t6_result", 64'(rsp_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    burst(1, 32'hF0F0, 32'h0FF0, 3'd4);
    idle(1);
    check("t6_after", 64'(rsp_result), 64'h00F0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
